// File: rtl/cpu_params_pkg.sv
// rtl/cpu_params_pkg.sv - CSR instruction encodings and CSR address constants
package cpu_params_pkg;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // mip and sip share these low nine address bits
    localparam logic [8:0] CSR_IP_LO  = 9'h144;
    localparam logic [1:0] CSR_RO_TAG = 2'b11;

endpackage

// File: rtl/cpu_structs_pkg.sv
// rtl/cpu_structs_pkg.sv - shared state types for the CSR read-modify-write path
package cpu_structs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } rmw_state_t;

endpackage

// File: rtl/csr_rmw_calc.sv
// rtl/csr_rmw_calc.sv - combinational CSR legality, read/write op and interrupt merge
module csr_rmw_calc
    import cpu_params_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] IRQ_MASK = 32'h0000_0200
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      mode,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rd_addr,
    input  logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] old_data,
    input  logic [XLEN-1:0] irq_pend,
    output logic            ill,
    output logic            csr_rd,
    output logic            csr_wr,
    output logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] rw_data
);

    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] new_data;
    logic [XLEN-1:0] irq_bits;
    logic            rd_raw;
    logic            wr_raw;
    logic            bad_op;

    always_comb begin
        operand  = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_addr} : rs1_data;
        rd_raw   = 1'b0;
        wr_raw   = 1'b0;
        bad_op   = 1'b0;
        new_data = '0;
        case (funct3)
            F3_CSRRW, F3_CSRRWI: begin
                wr_raw   = 1'b1;
                rd_raw   = (rd_addr != 5'd0);
                new_data = operand;
            end
            F3_CSRRS, F3_CSRRSI: begin
                wr_raw   = (rs1_addr != 5'd0);
                rd_raw   = 1'b1;
                new_data = old_data | operand;
            end
            F3_CSRRC, F3_CSRRCI: begin
                wr_raw   = (rs1_addr != 5'd0);
                rd_raw   = 1'b1;
                new_data = old_data & ~operand;
            end
            default: bad_op = 1'b1;
        endcase

        // read-only space only faults when a write would actually happen
        ill      = bad_op || (mode < csr_addr[9:8]) ||
                   ((csr_addr[11:10] == CSR_RO_TAG) && wr_raw);
        csr_rd   = rd_raw && !ill;
        csr_wr   = wr_raw && !ill;
        wr_data  = ill ? '0 : new_data;
        irq_bits = (csr_addr[8:0] == CSR_IP_LO) ? (irq_pend & IRQ_MASK) : '0;
        rw_data  = csr_rd ? (old_data | irq_bits) : '0;
    end

endmodule

// File: rtl/csr_rmw_unit.sv
// rtl/csr_rmw_unit.sv - CSR read-modify-write sequencer with write-pending forwarding
module csr_rmw_unit
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              WAIT_MAX = 4,
    parameter logic [XLEN-1:0] IRQ_MASK = 32'h0000_0200
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rd_addr,
    input  logic [4:0]      rs1_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [2:0]      funct3,
    input  logic [1:0]      mode,
    input  logic [XLEN-1:0] irq_pend,
    output logic [11:0]     rd_csr_addr,
    input  logic [XLEN-1:0] csr_rd_data,
    input  logic            csr_rd_avail,
    input  logic            wb_commit,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_csr_rd,
    output logic            rsp_csr_wr,
    output logic [XLEN-1:0] rsp_rw_data,
    output logic [XLEN-1:0] rsp_wr_data,
    output logic            rsp_ill,
    output logic [11:0]     rsp_ill_addr
);

    rmw_state_t      state;
    logic [3:0]      wait_cnt;
    logic [2:0]      req_funct3;
    logic [1:0]      req_mode;
    logic [11:0]     req_csr_addr;
    logic [4:0]      req_rd_addr;
    logic [4:0]      req_rs1_addr;
    logic [XLEN-1:0] req_rs1_data;
    logic            pend_valid;
    logic [11:0]     pend_addr;
    logic [XLEN-1:0] pend_data;

    logic            accept;
    logic            rsp_fire;
    logic [XLEN-1:0] old_data;
    logic            calc_ill;
    logic            calc_rd;
    logic            calc_wr;
    logic [XLEN-1:0] calc_wr_data;
    logic [XLEN-1:0] calc_rw_data;

    assign req_ready   = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
    assign accept      = req_valid && req_ready;
    assign rsp_fire    = rsp_valid && rsp_ready;
    assign rd_csr_addr = req_csr_addr;
    // the CSR file has not seen a write still sitting in WB, so forward it
    assign old_data    = (pend_valid && (pend_addr == req_csr_addr)) ? pend_data : csr_rd_data;

    csr_rmw_calc #(
        .XLEN     (XLEN),
        .IRQ_MASK (IRQ_MASK)
    ) u_calc (
        .funct3   (req_funct3),
        .mode     (req_mode),
        .csr_addr (req_csr_addr),
        .rd_addr  (req_rd_addr),
        .rs1_addr (req_rs1_addr),
        .rs1_data (req_rs1_data),
        .old_data (old_data),
        .irq_pend (irq_pend),
        .ill      (calc_ill),
        .csr_rd   (calc_rd),
        .csr_wr   (calc_wr),
        .wr_data  (calc_wr_data),
        .rw_data  (calc_rw_data)
    );

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            req_funct3   <= '0;
            req_mode     <= '0;
            req_csr_addr <= '0;
            req_rd_addr  <= '0;
            req_rs1_addr <= '0;
            req_rs1_data <= '0;
            pend_valid   <= 1'b0;
            pend_addr    <= '0;
            pend_data    <= '0;
            rsp_valid    <= 1'b0;
            rsp_csr_rd   <= 1'b0;
            rsp_csr_wr   <= 1'b0;
            rsp_rw_data  <= '0;
            rsp_wr_data  <= '0;
            rsp_ill      <= 1'b0;
            rsp_ill_addr <= '0;
        end else if (flush) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            rsp_valid  <= 1'b0;
            pend_valid <= 1'b0;
        end else begin
            if (rsp_fire && rsp_csr_wr) begin
                pend_valid <= 1'b1;
                pend_addr  <= req_csr_addr;
                pend_data  <= rsp_wr_data;
            end else if (wb_commit) begin
                pend_valid <= 1'b0;
            end

            if (accept) begin
                req_funct3   <= funct3;
                req_mode     <= mode;
                req_csr_addr <= csr_addr;
                req_rd_addr  <= rd_addr;
                req_rs1_addr <= rs1_addr;
                req_rs1_data <= rs1_data;
                wait_cnt     <= '0;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) state <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (csr_rd_avail) begin
                        rsp_valid    <= 1'b1;
                        rsp_csr_rd   <= calc_rd;
                        rsp_csr_wr   <= calc_wr;
                        rsp_rw_data  <= calc_rw_data;
                        rsp_wr_data  <= calc_wr_data;
                        rsp_ill      <= calc_ill;
                        rsp_ill_addr <= calc_ill ? req_csr_addr : 12'h000;
                        state        <= ST_RESP;
                    end else if (wait_cnt == 4'(WAIT_MAX - 1)) begin
                        rsp_valid    <= 1'b1;
                        rsp_csr_rd   <= 1'b0;
                        rsp_csr_wr   <= 1'b0;
                        rsp_rw_data  <= '0;
                        rsp_wr_data  <= '0;
                        rsp_ill      <= 1'b1;
                        rsp_ill_addr <= req_csr_addr;
                        state        <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept ? ST_EVAL : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// tb/tb_csr_rmw_unit.sv - scoreboard bench for csr_rmw_unit against a reference model
module tb_csr_rmw_unit;

    localparam int WAIT_MAX = 4;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] csr_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [4:0]  rs1_addr = '0;
    logic [31:0] rs1_data = '0;
    logic [2:0]  funct3 = '0;
    logic [1:0]  mode = '0;
    logic [31:0] irq_pend = '0;
    logic [11:0] rd_csr_addr;
    logic [31:0] csr_rd_data = '0;
    logic        csr_rd_avail = 1'b0;
    logic        wb_commit = 1'b0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_csr_rd;
    logic        rsp_csr_wr;
    logic [31:0] rsp_rw_data;
    logic [31:0] rsp_wr_data;
    logic        rsp_ill;
    logic [11:0] rsp_ill_addr;

    csr_rmw_unit #(.XLEN(32), .WAIT_MAX(WAIT_MAX), .IRQ_MASK(32'h0000_0200)) dut (
        .clk_in(clk_in), .reset_in(reset_in), .req_valid(req_valid), .req_ready(req_ready),
        .csr_addr(csr_addr), .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .funct3(funct3), .mode(mode), .irq_pend(irq_pend), .rd_csr_addr(rd_csr_addr),
        .csr_rd_data(csr_rd_data), .csr_rd_avail(csr_rd_avail), .wb_commit(wb_commit),
        .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_csr_rd(rsp_csr_rd),
        .rsp_csr_wr(rsp_csr_wr), .rsp_rw_data(rsp_rw_data), .rsp_wr_data(rsp_wr_data),
        .rsp_ill(rsp_ill), .rsp_ill_addr(rsp_ill_addr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          ill;
        bit          rd;
        bit          wr;
        logic [31:0] rw;
        logic [31:0] wd;
        logic [11:0] ia;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          mp_valid = 1'b0;
    logic [11:0] mp_addr = '0;
    logic [31:0] mp_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural CSR rules: what the instruction should read and write
    function automatic exp_t model(input logic [2:0] f3, input logic [11:0] addr,
                                   input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [31:0] data, input logic [1:0] md,
                                   input logic [31:0] csr, input logic [31:0] irq,
                                   input int avail_delay);
        exp_t        e;
        logic [31:0] old;
        logic [31:0] src;
        bit          does_rd, does_wr, bad;
        logic [31:0] nv;
        e = '{ill: 0, rd: 0, wr: 0, rw: 0, wd: 0, ia: 0};
        if (avail_delay >= WAIT_MAX) begin
            e.ill = 1; e.ia = addr;
            return e;
        end
        old = (mp_valid && mp_addr == addr) ? mp_data : csr;
        src = (f3 >= 3'd5) ? 32'(rs1) : data;
        bad = 0; does_rd = 0; does_wr = 0; nv = 0;
        if (f3 == 3'd1 || f3 == 3'd5) begin
            does_wr = 1; does_rd = (rd != 0); nv = src;
        end else if (f3 == 3'd2 || f3 == 3'd6) begin
            does_wr = (rs1 != 0); does_rd = 1; nv = old | src;
        end else if (f3 == 3'd3 || f3 == 3'd7) begin
            does_wr = (rs1 != 0); does_rd = 1; nv = old & ~src;
        end else begin
            bad = 1;
        end
        if (bad || md < addr[9:8] || (addr[11:10] == 2'b11 && does_wr)) begin
            e.ill = 1; e.ia = addr;
            return e;
        end
        e.rd = does_rd;
        e.wr = does_wr;
        e.wd = nv;
        if (does_rd) e.rw = old | ((addr[8:0] == 9'h144) ? (irq & 32'h200) : 32'h0);
        return e;
    endfunction

    always @(negedge clk_in) begin
        if (reset_in === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rsp: got a response, expected none at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_ill", 32'(rsp_ill), 32'(e.ill));
                check("rsp_csr_rd", 32'(rsp_csr_rd), 32'(e.rd));
                check("rsp_csr_wr", 32'(rsp_csr_wr), 32'(e.wr));
                check("rsp_rw_data", rsp_rw_data, e.rw);
                check("rsp_wr_data", rsp_wr_data, e.wd);
                check("rsp_ill_addr", 32'(rsp_ill_addr), 32'(e.ia));
            end
        end
    end

    task automatic drive_req(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [31:0] data, input logic [1:0] md,
                             input logic [31:0] csr, input logic [31:0] irq);
        bit got = 0;
        funct3 = f3; csr_addr = addr; rd_addr = rd; rs1_addr = rs1; rs1_data = data;
        mode = md; csr_rd_data = csr; irq_pend = irq; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (req_ready) begin
                @(posedge clk_in); #1;
                got = 1;
                break;
            end
        end
        if (!got) check("accept_timeout", 32'(got), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic eval_phase(input int delay);
        bit done;
        for (int k = 0; k < WAIT_MAX + 1; k++) begin
            csr_rd_avail = (k >= delay);
            @(posedge clk_in); #1;
            done = (k >= delay) || (k + 1 == WAIT_MAX);
            check("rsp_valid_timing", 32'(rsp_valid), 32'(done));
            if (done) break;
        end
        csr_rd_avail = 1'b0;
    endtask

    task automatic finish_rsp(input int delay);
        bit seen = 0;
        rsp_ready = 1'b0;
        repeat (delay) begin @(posedge clk_in); #1; end
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (rsp_valid) begin seen = 1; break; end
        end
        if (!seen) check("rsp_timeout", 32'(seen), 32'd1);
        @(posedge clk_in); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [31:0] data, input logic [1:0] md,
                            input logic [31:0] csr, input logic [31:0] irq, input int ad);
        exp_t e;
        e = model(f3, addr, rd, rs1, data, md, csr, irq, ad);
        exp_q.push_back(e);
        if (e.wr) begin mp_valid = 1; mp_addr = addr; mp_data = e.wd; end
    endtask

    task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [31:0] data, input logic [1:0] md,
                           input logic [31:0] csr, input logic [31:0] irq, input int ad, input int rdly);
        push_exp(f3, addr, rd, rs1, data, md, csr, irq, ad);
        drive_req(f3, addr, rd, rs1, data, md, csr, irq);
        eval_phase(ad);
        finish_rsp(rdly);
    endtask

    task automatic commit_pulse();
        wb_commit = 1'b1;
        @(posedge clk_in); #1;
        wb_commit = 1'b0;
        mp_valid = 0;
    endtask

    function automatic logic [11:0] pick_addr(input int sel);
        case (sel)
            0: return 12'h300;
            1: return 12'h340;
            2: return 12'h344;
            3: return 12'h144;
            4: return 12'hC00;
            5: return 12'hC01;
            6: return 12'h100;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        #1 reset_in = 1'b0;
        #2;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rd_csr_addr", 32'(rd_csr_addr), 32'd0);
        check("reset_rsp_ill", 32'(rsp_ill), 32'd0);
        @(negedge clk_in); reset_in = 1'b1;
        @(posedge clk_in); #1;

        run_txn(3'd2, 12'h300, 5'd3, 5'd1, 32'd8, 2'd3, 32'd1, 32'd0, 0, 0);
        run_txn(3'd1, 12'hC00, 5'd3, 5'd5, 32'h77, 2'd3, 32'h1234, 32'd0, 0, 1);
        run_txn(3'd2, 12'hC00, 5'd3, 5'd0, 32'h77, 2'd3, 32'h1234, 32'd0, 0, 0);
        run_txn(3'd6, 12'hC01, 5'd4, 5'd0, 32'h0, 2'd0, 32'hABCD, 32'd0, 0, 0);
        run_txn(3'd2, 12'h344, 5'd3, 5'd2, 32'h8, 2'd3, 32'h0, 32'h200, 0, 0);
        run_txn(3'd2, 12'h300, 5'd3, 5'd2, 32'h10, 2'd3, 32'h5, 32'h0, 5, 0);
        run_txn(3'd2, 12'h300, 5'd3, 5'd2, 32'h10, 2'd3, 32'h5, 32'h0, 2, 2);
        run_txn(3'd0, 12'h300, 5'd3, 5'd2, 32'h10, 2'd3, 32'h5, 32'h0, 0, 0);
        run_txn(3'd1, 12'h300, 5'd3, 5'd2, 32'h10, 2'd1, 32'h5, 32'h0, 0, 0);

        // back-to-back CSRRSI imm=1 then imm=2 to 0x340 with the second accepted during RESP
        commit_pulse();
        push_exp(3'd6, 12'h340, 5'd1, 5'd1, 32'h0, 2'd3, 32'h0, 32'h0, 0);
        push_exp(3'd6, 12'h340, 5'd1, 5'd2, 32'h0, 2'd3, 32'h0, 32'h0, 0);
        drive_req(3'd6, 12'h340, 5'd1, 5'd1, 32'h0, 2'd3, 32'h0, 32'h0);
        eval_phase(0);
        rsp_ready = 1'b1;
        drive_req(3'd6, 12'h340, 5'd1, 5'd2, 32'h0, 2'd3, 32'h0, 32'h0);
        eval_phase(0);
        finish_rsp(0);

        // flush while a response is waiting: nothing is delivered, forwarding is dropped
        drive_req(3'd6, 12'h340, 5'd1, 5'd4, 32'h0, 2'd3, 32'h0, 32'h0);
        eval_phase(0);
        flush = 1'b1;
        @(posedge clk_in); #1;
        flush = 1'b0;
        mp_valid = 0;
        check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        check("flush_req_ready", 32'(req_ready), 32'd1);
        run_txn(3'd2, 12'h340, 5'd1, 5'd0, 32'h0, 2'd3, 32'h55, 32'h0, 0, 0);

        // asynchronous reset while a response is held
        drive_req(3'd1, 12'h340, 5'd1, 5'd3, 32'h99, 2'd3, 32'h0, 32'h0);
        eval_phase(0);
        #2 reset_in = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rd_csr_addr", 32'(rd_csr_addr), 32'd0);
        check("rst_rsp_wr_data", rsp_wr_data, 32'd0);
        mp_valid = 0;
        @(negedge clk_in); reset_in = 1'b1;
        @(posedge clk_in); #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        for (int n = 0; n < 80; n++) begin
            logic [4:0] rd, rs1;
            if ($urandom_range(0, 4) == 0) commit_pulse();
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rs1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_txn(3'($urandom_range(0, 7)), pick_addr($urandom_range(0, 7)), rd, rs1,
                    $urandom, 2'($urandom), $urandom, $urandom,
                    $urandom_range(0, 5), $urandom_range(0, 2));
        end

        repeat (3) @(posedge clk_in);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
